// File: rtl/debounce_bank.sv
// Multi-channel key debouncer: polarity fold, 2-flop synchroniser, stability
// window, one-cycle press/release pulses and optional auto-repeat per channel.
module debounce_bank #(
    parameter int                  CHANNELS      = 4,
    parameter int                  STABLE_CYCLES = 524288,
    parameter int                  HOLD_CYCLES   = 25000000,
    parameter int                  REPEAT_CYCLES = 5000000,
    parameter logic [CHANNELS-1:0] IN_POLARITY   = {CHANNELS{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_i,
    input  logic                repeat_en_i,
    output logic [CHANNELS-1:0] state_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o,
    output logic                any_active_o
);

    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int SW   = $clog2(STABLE_CYCLES);

    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_CYCLES - 1);

    if (CHANNELS < 1 || CHANNELS > 32 || STABLE_CYCLES < 2 ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("debounce_bank: illegal parameter value");
    end

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] repeat_q, repeat_d;
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [SW-1:0]       stab_q [CHANNELS];
    logic [SW-1:0]       stab_d [CHANNELS];
    logic [RW-1:0]       hold_q [CHANNELS];
    logic [RW-1:0]       hold_d [CHANNELS];

    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        phase_d   = phase_q;
        for (int i = 0; i < CHANNELS; i++) begin
            stab_d[i] = '0;
            hold_d[i] = '0;
            if (sync2_q[i] != state_q[i]) begin
                if (stab_q[i] == STABLE_LAST) begin
                    state_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    stab_d[i] = stab_q[i] + SW'(1);
                end
            end
            // Clearing looks at next-cycle state so the press cycle itself is count zero.
            if (!state_d[i] || !repeat_en_i || press_d[i]) begin
                phase_d[i] = 1'b0;
            end else if (hold_q[i] == (phase_q[i] ? REP_LAST : HOLD_LAST)) begin
                repeat_d[i] = 1'b1;
                phase_d[i]  = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            phase_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q   <= in_i ^ IN_POLARITY;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            phase_q   <= phase_d;
            for (int i = 0; i < CHANNELS; i++) begin
                stab_q[i] <= stab_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign state_o      = state_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign repeat_o     = repeat_q;
    assign any_active_o = |state_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: directed scenarios plus randomized
// pin activity compared against a window/elapsed-time reference model.
module tb_debounce_bank;

    localparam int CH = 2;
    localparam int ST = 8;
    localparam int HO = 20;
    localparam int RE = 5;
    localparam logic [1:0] POL = 2'b10;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [1:0] in_i      = 2'b00;
    logic       repeat_en = 1'b0;
    logic [1:0] state_o, press_o, release_o, repeat_o;
    logic       any_active_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(CH), .STABLE_CYCLES(ST), .HOLD_CYCLES(HO),
        .REPEAT_CYCLES(RE), .IN_POLARITY(POL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_i(in_i), .repeat_en_i(repeat_en),
        .state_o(state_o), .press_o(press_o), .release_o(release_o),
        .repeat_o(repeat_o), .any_active_o(any_active_o)
    );

    // Reference model: pins reach the window two edges late; a level change is
    // accepted once the last ST synchronised samples all oppose the current
    // state; repeats are timed from the most recent clearing event.
    logic [1:0] m_state, m_press, m_release, m_repeat, m_s;
    logic [1:0] m_pins [$];
    logic [1:0] m_hist [$];
    int         m_since [CH];

    logic [8:0] obs, mexp;
    assign obs  = {state_o, press_o, release_o, repeat_o, any_active_o};
    assign mexp = {m_state, m_press, m_release, m_repeat, |m_state};

    function automatic bit win_opposes(int c);
        for (int j = 0; j < m_hist.size(); j++)
            if (m_hist[j][c] == m_state[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_state = '0; m_press = '0; m_release = '0; m_repeat = '0;
        m_pins.delete();
        m_pins.push_back(2'b00);
        m_pins.push_back(2'b00);
        m_hist.delete();
        for (int c = 0; c < CH; c++) m_since[c] = 0;
    endtask

    task automatic model_step();
        m_s = m_pins.pop_front();
        m_pins.push_back(in_i ^ POL);
        m_hist.push_back(m_s);
        if (m_hist.size() > ST) void'(m_hist.pop_front());
        m_press = '0; m_release = '0; m_repeat = '0;
        for (int c = 0; c < CH; c++) begin
            if (m_hist.size() == ST && win_opposes(c)) begin
                m_state[c] = ~m_state[c];
                if (m_state[c]) m_press[c] = 1'b1;
                else            m_release[c] = 1'b1;
            end
            if (!m_state[c] || !repeat_en || m_press[c]) begin
                m_since[c] = 0;
            end else begin
                m_since[c]++;
                m_repeat[c] = (m_since[c] == HO) ||
                              (m_since[c] > HO && (m_since[c] - HO) % RE == 0);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic drive(input logic [1:0] act);
        in_i = act ^ POL;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_i = (i == 1) ? 2'b01 : 2'b00;
            @(negedge clk);
            tests++;
            if (obs !== 9'd0) begin
                fails++;
                $display("FAIL reset_outputs cyc=%0d got=%b want=%b", i, obs, 9'd0);
            end
        end
        in_i = 2'b00;
    endtask

    task automatic test_polarity();
        logic [3:0] want;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            want = {(k >= 10) ? 2'b10 : 2'b00, (k == 10) ? 2'b10 : 2'b00};
            tests += 2;
            if ({state_o, press_o} !== want) begin
                fails++;
                $display("FAIL polarity_press k=%0d got=%b want=%b", k, {state_o, press_o}, want);
            end
            if (obs !== mexp) begin
                fails++;
                $display("FAIL polarity_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
        in_i = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests += 2;
            if ({state_o[1], release_o[1]} !== {k < 10, k == 10}) begin
                fails++;
                $display("FAIL polarity_release k=%0d got=%b want=%b", k,
                         {state_o[1], release_o[1]}, {k < 10, k == 10});
            end
            if (obs !== mexp) begin
                fails++;
                $display("FAIL polarity_rel_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] want;
        drive(2'b01);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            want = {(k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, k >= 10};
            tests += 2;
            if ({state_o, press_o, any_active_o} !== want) begin
                fails++;
                $display("FAIL clean_press k=%0d got=%b want=%b", k,
                         {state_o, press_o, any_active_o}, want);
            end
            if (obs !== mexp) begin
                fails++;
                $display("FAIL clean_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
        drive(2'b00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL clean_rel_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
    endtask

    task automatic test_bounce();
        int npress;
        int at;
        npress = 0;
        at = -1;
        for (int c = 0; c <= 44; c++) begin
            drive((c >= 30 || (c / 3) % 2 == 0) ? 2'b01 : 2'b00);
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL bounce_model c=%0d got=%b want=%b", c, obs, mexp);
            end
            if (press_o[0]) begin
                npress++;
                if (at < 0) at = c - 29;
            end
        end
        tests += 2;
        if (npress != 1) begin
            fails++;
            $display("FAIL bounce_press_count got=%0d want=1", npress);
        end
        if (at != 10) begin
            fails++;
            $display("FAIL bounce_press_delay got=%0d want=10", at);
        end
        drive(2'b00);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL bounce_rel_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
    endtask

    task automatic test_window();
        int np, nr, ns;
        for (int pass = 0; pass < 2; pass++) begin
            np = 0; nr = 0; ns = 0;
            for (int c = 0; c < 28; c++) begin
                drive((c < 7 + pass) ? 2'b10 : 2'b00);
                @(negedge clk);
                tests++;
                if (obs !== mexp) begin
                    fails++;
                    $display("FAIL window_model pass=%0d c=%0d got=%b want=%b", pass, c, obs, mexp);
                end
                np += int'(press_o[1]);
                nr += int'(release_o[1]);
                ns += int'(state_o[1]);
            end
            tests += 2;
            if (np != pass || nr != pass) begin
                fails++;
                $display("FAIL window_events pass=%0d got press=%0d release=%0d want %0d each",
                         pass, np, nr, pass);
            end
            if ((ns != 0) !== (pass == 1)) begin
                fails++;
                $display("FAIL window_state pass=%0d got active_cycles=%0d", pass, ns);
            end
        end
    endtask

    task automatic test_repeat();
        int reps [$];
        bit found;
        int nrel, late;
        for (int part = 0; part < 2; part++) begin
            repeat_en = 1'b1;
            drive(2'b01);
            found = 1'b0;
            for (int i = 0; i < 16 && !found; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== mexp) begin
                    fails++;
                    $display("FAIL repeat_wait_model i=%0d got=%b want=%b", i, obs, mexp);
                end
                if (press_o[0]) found = 1'b1;
            end
            tests++;
            if (!found) begin
                fails++;
                $display("FAIL repeat_press_seen part=%0d got=0 want=1", part);
            end
            reps.delete();
            for (int k = 1; k <= ((part == 0) ? 34 : 50); k++) begin
                @(negedge clk);
                tests++;
                if (obs !== mexp) begin
                    fails++;
                    $display("FAIL repeat_model part=%0d k=%0d got=%b want=%b", part, k, obs, mexp);
                end
                if (repeat_o[0]) reps.push_back(k);
                if (part == 1 && k == 22) repeat_en = 1'b0;
                if (part == 1 && k == 23) repeat_en = 1'b1;
            end
            tests++;
            if (reps.size() != 3 ||
                reps[0] != 20 || reps[1] != ((part == 0) ? 25 : 43) ||
                reps[2] != ((part == 0) ? 30 : 48)) begin
                fails++;
                $display("FAIL repeat_times part=%0d got=%p want=%s", part, reps,
                         (part == 0) ? "20 25 30" : "20 43 48");
            end
            drive(2'b00);
            nrel = 0;
            late = 0;
            for (int j = 1; j <= 20; j++) begin
                @(negedge clk);
                tests++;
                if (obs !== mexp) begin
                    fails++;
                    $display("FAIL repeat_drop_model j=%0d got=%b want=%b", j, obs, mexp);
                end
                if (nrel > 0 && repeat_o[0]) late++;
                nrel += int'(release_o[0]);
            end
            tests++;
            if (nrel != 1 || late != 0) begin
                fails++;
                $display("FAIL repeat_drop part=%0d got release=%0d late_repeats=%0d want 1,0",
                         part, nrel, late);
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        bit found;
        int pk, rk;
        repeat_en = 1'b1;
        drive(2'b01);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (press_o[0]) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL midreset_press_seen got=0 want=1");
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL midreset_hold_model k=%0d got=%b want=%b", k, obs, mexp);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 9'd0) begin
            fails++;
            $display("FAIL midreset_async_clear got=%b want=%b", obs, 9'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pk = -1;
        rk = -1;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL midreset_model k=%0d got=%b want=%b", k, obs, mexp);
            end
            if (press_o[0] && pk < 0) pk = k;
            if (repeat_o[0] && rk < 0) rk = k;
        end
        tests += 2;
        if (pk != 10) begin
            fails++;
            $display("FAIL midreset_press_delay got=%0d want=10", pk);
        end
        if (rk != 30) begin
            fails++;
            $display("FAIL midreset_first_repeat got=%0d want=30", rk);
        end
        drive(2'b00);
        repeat_en = 1'b0;
        for (int k = 0; k < 14; k++) @(negedge clk);
    endtask

    task automatic test_random();
        int         rlen [CH];
        logic [1:0] act;
        act = 2'b00;
        for (int c = 0; c < CH; c++) rlen[c] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if (rlen[c] == 0) begin
                    act[c]  = 1'($urandom_range(0, 1));
                    rlen[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 60))
                                                          : int'($urandom_range(1, 10));
                end
                rlen[c]--;
            end
            if ($urandom_range(0, 99) < 3) repeat_en = ~repeat_en;
            drive(act);
            @(negedge clk);
            tests++;
            if (obs !== mexp) begin
                fails++;
                $display("FAIL random_model n=%0d got=%b want=%b", n, obs, mexp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_polarity();
        test_clean_press();
        test_bounce();
        test_window();
        test_repeat();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Multi-channel successor to the single-input debouncer, for the calculator keypad and front-panel buttons. Each channel has:
- a 2-flop synchroniser and a programmable stability window;
- per-channel input polarity;
- one-cycle press and release pulses;
- optional auto-repeat while held.

It sits between raw pins and the key decoder/FSM, so downstream logic sees only clean levels and single-cycle events.

Parameters:
CHANNELS, 4, number of independent inputs (1..32)
STABLE_CYCLES, 524288, consecutive cycles a new level must persist before the debounced state changes (>=2)
HOLD_CYCLES, 25000000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_CYCLES, 5000000, cycles between successive repeat pulses (>=1)
IN_POLARITY, {CHANNELS{1'b0}}, per-channel mask; bit=1 means pin is active-low
Internal counter widths are derived as $clog2(max value+1); no width parameters are exposed.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in  input  CHANNELS  raw asynchronous pins
repeat_en  input  1  global auto-repeat enable, synchronous to clk
state  output  CHANNELS  debounced level, 1 = active
press  output  CHANNELS  1-cycle pulse on debounced inactive->active
release  output  CHANNELS  1-cycle pulse on debounced active->inactive
repeat  output  CHANNELS  1-cycle auto-repeat pulse while held
any_active  output  1  OR of state

Behaviour:
- Reset:
  - rst_n low asynchronously clears synchronisers, all counters, state, press, release and repeat to 0.
  - any_active follows state, so it is also 0.
- Polarity: in is XORed with IN_POLARITY before the synchroniser, so everything downstream is active-high.
- Sync: 2 flops per channel. Only the second-flop output (s) is used.
- Stability counter per channel:
  - Cycle with s == state: counter cleared.
  - Cycle with s != state: counter increments.
  - On the edge where the counter equals STABLE_CYCLES-1 and s still differs, state takes s and the counter clears.
  - So s must differ for exactly STABLE_CYCLES consecutive cycles. Total pin-to-state latency is 2+STABLE_CYCLES edges.
  - A single-cycle return to the old level restarts the window.
  - The counter never wraps.
- Event pulses:
  - press[i] is high exactly in the first cycle state[i] is 1; release[i] exactly in the first cycle state[i] is 0.
  - All event outputs are registered, never combinational from in.
- Auto-repeat, per channel:
  - Hold counter and phase bit are cleared whenever state[i]==0, repeat_en==0, or press[i] is high.
  - Otherwise the counter increments each cycle.
  - Phase 0: when the counter reaches HOLD_CYCLES-1, repeat[i] pulses, the counter clears and phase becomes 1.
  - Phase 1: pulse, then clear, each time the counter reaches REPEAT_CYCLES-1.
  - Result: the first repeat is HOLD_CYCLES cycles after press, then one every REPEAT_CYCLES.
  - repeat never coincides with press or release.
  - Deasserting repeat_en mid-hold stops pulses. Re-asserting restarts the full HOLD_CYCLES delay.
- Channels are fully independent. Simultaneous events on several channels all appear in the same cycle.
- Reset mid-operation: a pin held active across reset release produces a normal press 2+STABLE_CYCLES cycles after rst_n rises.
- A simulation-only check flags illegal parameter values at elaboration.

Test Plan:
Common parameters: CHANNELS=2, STABLE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, IN_POLARITY=0, repeat_en=0 unless noted.
1. in[0] 0->1 cleanly, sampled at edge T:
   - state[0]=1 from edge T+10; press[0] high for exactly that one cycle.
   - Channel 1 outputs stay 0; any_active=1.
2. in[0] toggles every 3 cycles for 30 cycles, then stays 1:
   - no press during bouncing;
   - exactly one press, 10 edges after the final transition.
3. Stability window, from idle:
   - in[1] high for 7 cycles then low: state[1] stays 0, no pulses.
   - Same with 8+2 cycles high: state[1] rises and press[1] fires once.
   - Then low for 10+ cycles: release[1] fires once.
4. repeat_en=1, in[0] held:
   - press at cycle P; repeat[0] at P+20, P+25, P+30.
   - Drop in[0]: release fires, repeats stop.
   - Toggling repeat_en 1->0->1 at P+22 moves the next repeat to 20 cycles after re-enable.
5. IN_POLARITY=2'b10, both pins 0 at reset release:
   - state=2'b10 after 10 cycles, press[1] fires;
   - driving in[1]=1 gives release[1].
6. Reset mid-hold, repeat_en=1, in[0] held active:
   - pulse rst_n low asynchronously mid-cycle: all outputs 0 immediately;
   - after rst_n rises, press[0] fires 10 edges later and repeats resume from HOLD_CYCLES.
